// File: rtl/fm_readback_controller.sv
// FM RAM readback: streams a contiguous FM region out as valid/ready words via a credit-controlled FIFO.
// Optional running output checksum enabled by defining FM_READBACK_CHECKSUM_EN.
module fm_readback_controller #(
   parameter int ADDR_WIDTH = 19,
   parameter int DATA_WIDTH = 16,
   parameter int LEN_WIDTH  = 18,
   parameter int RD_LATENCY = 2,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cmd_start,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [LEN_WIDTH-1:0]  cmd_len,
   output logic                  busy,
   output logic                  done,
   output logic                  FMReadEn,
   output logic [ADDR_WIDTH-1:0] FMReadAddr,
   input  logic [DATA_WIDTH-1:0] FMReadData,
   output logic                  out_valid,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_last,
   input  logic                  out_ready
`ifdef FM_READBACK_CHECKSUM_EN
   ,
   output logic [15:0]           checksum
`endif
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = $clog2(FIFO_DEPTH + RD_LATENCY + 2) + 1;

   typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

   state_t                state;
   logic [ADDR_WIDTH-1:0] addr_reg;
   logic [LEN_WIDTH-1:0]  len_reg;
   logic [LEN_WIDTH-1:0]  issued_count;
   logic [LEN_WIDTH-1:0]  popped_count;
   logic [RD_LATENCY-1:0] vld_sr;

   logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0]      wr_ptr;
   logic [PTR_W-1:0]      rd_ptr;
   logic [PTR_W:0]        fifo_count;

   logic                  push;
   logic                  pop;
   logic                  issue;
   logic                  last_issue;
   logic                  final_pop;
   logic [PTR_W-1:0]      rd_ptr_next;
   logic [PTR_W:0]        count_after_pop;
   logic [PTR_W:0]        count_next;
   logic [CNT_W-1:0]      inflight;
   logic [CNT_W-1:0]      credit_used;
   logic [LEN_WIDTH-1:0]  popped_next;
   logic [DATA_WIDTH-1:0] head_next;

   // Credit counts the pop on this edge so a full pipeline sustains one word per cycle.
   always_comb begin
      push            = vld_sr[RD_LATENCY-1];
      pop             = out_valid && out_ready;
      count_after_pop = fifo_count - (PTR_W+1)'(pop);
      count_next      = count_after_pop + (PTR_W+1)'(push);
      rd_ptr_next     = rd_ptr + PTR_W'(pop);
      inflight        = CNT_W'(FMReadEn);
      for (int i = 0; i < RD_LATENCY; i++) begin
         inflight = inflight + CNT_W'(vld_sr[i]);
      end
      credit_used     = inflight + CNT_W'(fifo_count);
      issue           = (state == READ) && (issued_count != len_reg) &&
                        (credit_used < CNT_W'(FIFO_DEPTH) + CNT_W'(pop));
      last_issue      = issue && (issued_count == len_reg - LEN_WIDTH'(1));
      final_pop       = pop && (popped_count == len_reg - LEN_WIDTH'(1));
      popped_next     = popped_count + LEN_WIDTH'(pop);
      head_next       = (count_after_pop == '0) ? FMReadData : mem[rd_ptr_next];
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= FMReadData;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_sr <= '0;
      end else begin
         vld_sr[0] <= FMReadEn;
         for (int i = 1; i < RD_LATENCY; i++) begin
            vld_sr[i] <= vld_sr[i-1];
         end
      end
   end

   // out_data/out_valid form the registered head stage of the FIFO.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         out_valid  <= 1'b0;
         out_data   <= '0;
         out_last   <= 1'b0;
      end else begin
         wr_ptr     <= wr_ptr + PTR_W'(push);
         rd_ptr     <= rd_ptr_next;
         fifo_count <= count_next;
         out_valid  <= (count_next != '0);
         out_last   <= (count_next != '0) && (popped_next == len_reg - LEN_WIDTH'(1));
         if (count_next != '0) begin
            out_data <= head_next;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         busy         <= 1'b0;
         done         <= 1'b0;
         FMReadEn     <= 1'b0;
         FMReadAddr   <= '0;
         addr_reg     <= '0;
         len_reg      <= '0;
         issued_count <= '0;
         popped_count <= '0;
      end else begin
         FMReadEn <= issue;
         if (issue) begin
            FMReadAddr   <= addr_reg;
            addr_reg     <= addr_reg + ADDR_WIDTH'(1);
            issued_count <= issued_count + LEN_WIDTH'(1);
         end
         if (pop) begin
            popped_count <= popped_next;
         end
         case (state)
            IDLE: begin
               if (cmd_start) begin
                  addr_reg     <= cmd_addr;
                  len_reg      <= cmd_len;
                  issued_count <= '0;
                  popped_count <= '0;
                  busy         <= 1'b1;
                  state        <= (cmd_len == '0) ? DONE : READ;
               end
            end
            READ: begin
               if (last_issue) begin
                  state <= DRAIN;
               end
            end
            DRAIN: begin
               if (final_pop) begin
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= DONE;
               end
            end
            DONE: begin
               // A zero-length command arrives here with done still low.
               if (done) begin
                  done  <= 1'b0;
                  state <= IDLE;
               end else begin
                  done <= 1'b1;
                  busy <= 1'b0;
               end
            end
         endcase
      end
   end

`ifdef FM_READBACK_CHECKSUM_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         checksum <= '0;
      end else if (state == IDLE && cmd_start) begin
         checksum <= '0;
      end else if (pop) begin
         checksum <= checksum + 16'(out_data);
      end
   end
`endif

   a_no_overflow: assert property (@(posedge clk) disable iff (rst)
      !(push && !pop && fifo_count == (PTR_W+1)'(FIFO_DEPTH)));

endmodule

// File: tb/tb_fm_readback_controller.sv
// Scoreboard bench for fm_readback_controller: expected addresses/words queued at command time.
module tb_fm_readback_controller;

   localparam int FIFO_DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cmd_start = 1'b0;
   logic [18:0] cmd_addr = '0;
   logic [17:0] cmd_len = '0;
   logic        busy, done, FMReadEn, out_valid, out_last;
   logic [18:0] FMReadAddr;
   logic [15:0] FMReadData = '0;
   logic [15:0] out_data;
   logic        out_ready = 1'b1;
`ifdef FM_READBACK_CHECKSUM_EN
   logic [15:0] checksum;
`endif

   fm_readback_controller dut (
      .clk(clk), .rst(rst), .cmd_start(cmd_start), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
      .busy(busy), .done(done), .FMReadEn(FMReadEn), .FMReadAddr(FMReadAddr),
      .FMReadData(FMReadData), .out_valid(out_valid), .out_data(out_data),
      .out_last(out_last), .out_ready(out_ready)
`ifdef FM_READBACK_CHECKSUM_EN
      , .checksum(checksum)
`endif
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int t_start, en_count, hs_count, valid_count, first_en, first_valid, done_cyc;
   logic        busy_t;
   logic        prev_stall = 1'b0;
   logic [15:0] prev_data  = '0;
   logic [15:0] ram_p1     = '0;
   logic [18:0] exp_addr[$];
   logic [16:0] exp_data[$];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [15:0] ram_val(input logic [18:0] a);
      case (a)
         19'd500: return 16'd1;
         19'd501: return 16'd2;
         19'd502: return 16'hFFFF;
         default: return a[15:0];
      endcase
   endfunction

   always @(posedge clk) begin
      cyc        <= cyc + 1;
      ram_p1     <= FMReadEn ? ram_val(FMReadAddr) : 16'hDEAD;
      FMReadData <= ram_p1;
   end

   // Monitor: reads checked before handshakes so the credit check sees completed pops only.
   always @(negedge clk) begin
      if (rst) begin
         prev_stall = 1'b0;
      end else begin
         if (FMReadEn) begin
            en_count++;
            if (first_en < 0) first_en = cyc;
            if (exp_addr.size() == 0) check_eq("extra_read", 1, 0);
            else check_eq("rd_addr", 32'(FMReadAddr), 32'(exp_addr.pop_front()));
            check_eq("credit", 32'(en_count - hs_count <= FIFO_DEPTH), 1);
         end
         if (prev_stall) begin
            check_eq("stall_valid", 32'(out_valid), 1);
            check_eq("stall_data", 32'(out_data), 32'(prev_data));
         end
         if (out_valid) begin
            valid_count++;
            if (first_valid < 0) first_valid = cyc;
         end
         if (out_valid && out_ready) begin
            hs_count++;
            if (exp_data.size() == 0) check_eq("extra_word", 1, 0);
            else begin
               logic [16:0] e;
               e = exp_data.pop_front();
               check_eq("out_data", 32'(out_data), 32'(e[15:0]));
               check_eq("out_last", 32'(out_last), 32'(e[16]));
               $display("word %0d: data=0x%04h last=%0b cycle %0d", hs_count, out_data, out_last, cyc);
            end
         end
         if (done) begin
            done_cyc = cyc;
            check_eq("busy_at_done", 32'(busy), 0);
         end
         prev_stall = out_valid && !out_ready;
         prev_data  = out_data;
      end
   end

   task automatic start_cmd(input logic [18:0] a, input logic [17:0] n);
      @(posedge clk); #1;
      cmd_start = 1'b1; cmd_addr = a; cmd_len = n;
      t_start = cyc + 1;
      en_count = 0; hs_count = 0; valid_count = 0;
      first_en = -1; first_valid = -1; done_cyc = -1;
      for (int i = 0; i < int'(n); i++) begin
         exp_addr.push_back(19'(a + 19'(i)));
         exp_data.push_back({(i == int'(n) - 1), ram_val(19'(a + 19'(i)))});
      end
      @(posedge clk); #1;
      busy_t = busy;
      cmd_start = 1'b0;
      $display("cmd addr=0x%05h len=%0d accepted at cycle %0d", a, n, t_start);
   endtask

   task automatic wait_done();
      for (int k = 0; k < 600; k++) begin
         if (done_cyc >= 0) break;
         @(negedge clk);
      end
      #1;
      check_eq("done_seen", 32'(done_cyc >= 0), 1);
   endtask

   initial begin
      en_count = 0; hs_count = 0; valid_count = 0;
      first_en = -1; first_valid = -1; done_cyc = -1;
      repeat (2) @(posedge clk);
      #1;
      check_eq("rst_busy", 32'(busy), 0);
      check_eq("rst_valid", 32'(out_valid), 0);
      check_eq("rst_en", 32'(FMReadEn), 0);
      rst = 1'b0;

      // Basic 4-word read with exact latency.
      start_cmd(19'd100, 18'd4);
      check_eq("t1_busy", 32'(busy_t), 1);
      wait_done();
      check_eq("t1_first_en", 32'(first_en), 32'(t_start + 1));
      check_eq("t1_en_count", 32'(en_count), 4);
      check_eq("t1_first_valid", 32'(first_valid), 32'(t_start + 4));
      check_eq("t1_done_cyc", 32'(done_cyc), 32'(t_start + 8));
      check_eq("t1_words", 32'(hs_count), 4);

      // Zero-length command.
      start_cmd(19'd50, 18'd0);
      check_eq("t2_busy", 32'(busy_t), 1);
      wait_done();
      check_eq("t2_done_cyc", 32'(done_cyc), 32'(t_start + 1));
      check_eq("t2_no_reads", 32'(en_count), 0);
      check_eq("t2_no_valid", 32'(valid_count), 0);

      // Address wrap, with a stray cmd_start while busy.
      start_cmd(19'h7FFFE, 18'd4);
      cmd_start = 1'b1; cmd_addr = 19'd999; cmd_len = 18'd7;
      @(posedge clk); #1;
      cmd_start = 1'b0;
      wait_done();
      check_eq("t3_en_count", 32'(en_count), 4);
      check_eq("t3_words", 32'(hs_count), 4);

      // Random backpressure including a 10-cycle stall.
      start_cmd(19'd1000, 18'd16);
      for (int k = 0; k < 400; k++) begin
         if (done_cyc >= 0) break;
         @(posedge clk); #1;
         if (k == 13) check_eq("t4_credits_full", 32'(en_count - hs_count), FIFO_DEPTH);
         out_ready = (k >= 3 && k <= 12) ? 1'b0 : 1'(($urandom_range(0, 1)));
      end
      out_ready = 1'b1;
      wait_done();
      check_eq("t4_words", 32'(hs_count), 16);
      check_eq("t4_queue_empty", 32'(exp_data.size()), 0);

      // Reset mid-transfer.
      start_cmd(19'd0, 18'd16);
      for (int k = 0; k < 200; k++) begin
         if (hs_count >= 5) break;
         @(negedge clk);
      end
      check_eq("t5_reached_5", 32'(hs_count >= 5), 1);
      #2 rst = 1'b1;
      #1;
      check_eq("t5_rst_out", 32'({busy, done, FMReadEn, out_valid, out_last}), 0);
      check_eq("t5_rst_addr", 32'(FMReadAddr), 0);
      check_eq("t5_rst_data", 32'(out_data), 0);
      exp_addr.delete();
      exp_data.delete();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      start_cmd(19'd200, 18'd2);
      wait_done();
      check_eq("t5_words", 32'(hs_count), 2);
      check_eq("t5_reads", 32'(en_count), 2);

`ifdef FM_READBACK_CHECKSUM_EN
      start_cmd(19'd500, 18'd3);
      wait_done();
      check_eq("t6_checksum", 32'(checksum), 32'h0002);
`endif

      repeat (3) @(posedge clk);
      #1;
      check_eq("end_addr_queue", 32'(exp_addr.size()), 0);
      check_eq("end_data_queue", 32'(exp_data.size()), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fm_readback_controller.md
Name: fm_readback_controller

Overview:
Reads a contiguous region of the layer data (FM) RAM and streams it out as 16-bit words over a valid/ready interface, e.g. conv-layer results for the pooling stage or for host dump. It is the read-side counterpart of the FM loader: it drives the FM RAM read port and absorbs the RAM's fixed read latency with a credit-controlled output FIFO. Single command at a time; busy/done handshake toward the layer controller.

Parameters:
ADDR_WIDTH, 19, FM RAM address width
DATA_WIDTH, 16, FM word width
LEN_WIDTH, 18, transfer length width (max 227*227*3 words)
RD_LATENCY, 2, FM RAM cycles from FMReadEn/FMReadAddr to valid FMReadData (>=1)
FIFO_DEPTH, 4, output FIFO entries (power of 2, >= RD_LATENCY+1 for full throughput)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
cmd_start  in  1  single-cycle request; sampled only in IDLE
cmd_addr  in  ADDR_WIDTH  first FM address
cmd_len  in  LEN_WIDTH  number of words to read
busy  out  1  high from accepted cmd_start until done pulse
done  out  1  one-cycle pulse after last word handshaken
FMReadEn  out  1  FM RAM read enable
FMReadAddr  out  ADDR_WIDTH  FM RAM read address
FMReadData  in  DATA_WIDTH  FM RAM read data, valid RD_LATENCY cycles after FMReadEn
out_valid  out  1  out_data valid
out_data  out  DATA_WIDTH  streamed word
out_last  out  1  qualifies final word of transfer
out_ready  in  1  downstream accept; transfer when out_valid && out_ready

Behaviour:
- Reset (any time, incl. mid-transfer): state IDLE; busy, done, FMReadEn, out_valid, out_last = 0; FMReadAddr, out_data = 0; FIFO flushed, in-flight read pipeline cleared, counters zeroed. Returned RAM data after reset is discarded.
- States: IDLE, READ, DRAIN, DONE.
- IDLE: cmd_start=1 latches addr/len, busy=1 next cycle. cmd_len!=0 -> READ; cmd_len==0 -> DONE directly (no RAM reads, no out_valid).
- READ: issue one read per cycle when credit available: outstanding_reads + fifo_count < FIFO_DEPTH. Issue = FMReadEn=1, FMReadAddr=current address; address += 1 modulo 2^ADDR_WIDTH (wraps 2^19-1 -> 0); issued_count += 1. After issuing cmd_len reads -> DRAIN. FMReadEn=0 on cycles without issue.
- Read return: RD_LATENCY-deep valid shift register tracks in-flight reads; on its output, FMReadData is pushed into FIFO. Credit rule guarantees push never hits full FIFO (overflow is a design error, assert in sim).
- Output: out_valid = FIFO not empty; out_data = FIFO head (registered). Pop on out_valid && out_ready. out_data/out_valid held stable while out_ready=0. out_last=1 when head is word number cmd_len (tracked by popped_count == cmd_len-1).
- DRAIN: no issues; leave when final word popped -> DONE.
- DONE: done=1 for exactly one cycle, busy=0 same cycle; -> IDLE. cmd_start accepted in IDLE the following cycle.
- cmd_start while busy: ignored, no effect.
- Latency: cmd_start sampled at edge T -> first FMReadEn in cycle T+1 -> first out_valid in cycle T+2+RD_LATENCY (T+4 at default). Throughput: 1 word/cycle with out_ready held high and FIFO_DEPTH >= RD_LATENCY+1.
- Simultaneous push and pop on the same cycle: both occur; fifo_count unchanged.
- Counters: issued_count, popped_count LEN_WIDTH bits; no overflow for cmd_len <= 2^LEN_WIDTH-1.

Optional Feature:
FM_READBACK_CHECKSUM_EN: when defined, adds output checksum [15:0], reset 0, cleared at accepted cmd_start, += out_data (mod 2^16) on every output handshake; final value stable from done pulse until next accepted cmd_start. When undefined, port and logic are absent; all other behaviour identical.

Test Plan:
- RAM model preloaded addr=value; cmd_addr=100, cmd_len=4, out_ready=1 -> FMReadEn cycles T+1..T+4, out_data 100,101,102,103 on cycles T+4..T+7, out_last only with 103, done pulse at T+8, busy low same cycle.
- cmd_len=0 -> busy one cycle, done pulse, no FMReadEn, no out_valid.
- cmd_addr=0x7FFFE, cmd_len=4 -> addresses 0x7FFFE,0x7FFFF,0x00000,0x00001, data in that order.
- cmd_len=16, out_ready toggled random (incl. low 10 cycles) -> all 16 words in order, no loss/duplication, out_data stable while stalled, FMReadEn stops when credits exhausted.
- rst asserted mid-transfer (after 5 of 16 words) -> all outputs 0 immediately; new cmd_addr=200, cmd_len=2 yields exactly 200,201.
- With FM_READBACK_CHECKSUM_EN, words 1,2,0xFFFF -> checksum 0x0002 at done.
